// File: rtl/mdu_ctrl.sv
// HI/LO owner and multi-cycle multiply/divide sequencer for the E stage.
// Optional macro MDU_MADD_EN enables op 7 (madd: {hi,lo} += signed d1*d2).
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,   // 1..31
    parameter int DIV_CYCLES  = 10   // 1..31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MADD  = 3'd7;

    localparam logic [4:0] MUL_LOAD = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  count;
    logic [31:0] rhi;
    logic [31:0] rlo;

    logic        accept;
    logic [63:0] sa;
    logic [63:0] sb;
    logic [63:0] smul;
    logic [63:0] umul;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] squo;
    logic [31:0] srem;
    logic [31:0] b_udiv;
    logic [31:0] uquo;
    logic [31:0] urem;
    logic [63:0] div_res;
    logic [63:0] divu_res;
`ifdef MDU_MADD_EN
    logic [63:0] madd_res;
`endif

    assign accept = start && !req && (state == IDLE);

    // Datapath results are formed from the operands present at the accepting edge.
    always_comb begin
        sa   = {{32{d1[31]}}, d1};
        sb   = {{32{d2[31]}}, d2};
        smul = sa * sb;
        umul = {32'd0, d1} * {32'd0, d2};
    end

    // Signed divide via magnitudes; 0x80000000 / -1 falls out naturally as
    // quotient 0x80000000, remainder 0, so no separate overflow path is needed.
    always_comb begin
        a_mag  = d1[31] ? (32'd0 - d1) : d1;
        b_mag  = d2[31] ? (32'd0 - d2) : d2;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        squo   = (d1[31] ^ d2[31]) ? (32'd0 - q_mag) : q_mag;
        srem   = d1[31] ? (32'd0 - r_mag) : r_mag;
        if (d2 == 32'd0) begin
            div_res = {d1, 32'hFFFF_FFFF};
        end else begin
            div_res = {srem, squo};
        end
    end

    always_comb begin
        b_udiv = (d2 == 32'd0) ? 32'd1 : d2;
        uquo   = d1 / b_udiv;
        urem   = d1 % b_udiv;
        if (d2 == 32'd0) begin
            divu_res = {d1, 32'hFFFF_FFFF};
        end else begin
            divu_res = {urem, uquo};
        end
    end

`ifdef MDU_MADD_EN
    // Accumulates onto HI/LO as they stand at the accepting edge.
    assign madd_res = {hi, lo} + smul;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= 5'd0;
            busy  <= 1'b0;
            rhi   <= 32'd0;
            rlo   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT: begin
                                state      <= MUL;
                                count      <= MUL_LOAD;
                                busy       <= 1'b1;
                                {rhi, rlo} <= smul;
                            end
                            OP_MULTU: begin
                                state      <= MUL;
                                count      <= MUL_LOAD;
                                busy       <= 1'b1;
                                {rhi, rlo} <= umul;
                            end
                            OP_DIV: begin
                                state      <= DIV;
                                count      <= DIV_LOAD;
                                busy       <= 1'b1;
                                {rhi, rlo} <= div_res;
                            end
                            OP_DIVU: begin
                                state      <= DIV;
                                count      <= DIV_LOAD;
                                busy       <= 1'b1;
                                {rhi, rlo} <= divu_res;
                            end
                            OP_MTHI: hi <= d1;
                            OP_MTLO: lo <= d1;
`ifdef MDU_MADD_EN
                            OP_MADD: begin
                                state      <= MUL;
                                count      <= MUL_LOAD;
                                busy       <= 1'b1;
                                {rhi, rlo} <= madd_res;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    // req is ignored here: the owning instruction is older than any fault.
                    count <= count - 5'd1;
                    if (count == 5'd1) begin
                        hi    <= rhi;
                        lo    <= rlo;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    logic unused_op_madd;
    assign unused_op_madd = ^OP_MADD;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed table, hand sequences and a randomized
// run against an arithmetic reference model of HI/LO.
module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        req;
    logic        start;
    logic [2:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .start (start),
        .op    (op),
        .d1    (d1),
        .d2    (d2),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        int          e_lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference: architectural effect of one accepted op; returns busy length.
    function automatic int model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd1: begin p = sa * sb; {m_hi, m_lo} = p; return MC; end
            3'd2: begin p = ua * ub; {m_hi, m_lo} = p; return MC; end
            3'd3: begin
                if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
                else begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
                return DC;
            end
            3'd4: begin
                if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
                else begin p = ua / ub; m_lo = p[31:0]; p = ua % ub; m_hi = p[31:0]; end
                return DC;
            end
            3'd5: begin m_hi = a; return 0; end
            3'd6: begin m_lo = a; return 0; end
`ifdef MDU_MADD_EN
            3'd7: begin p = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} + p; return MC; end
`endif
            default: return 0;
        endcase
    endfunction

    // Present one start for one edge, then count busy cycles (bounded).
    task automatic do_op(input logic [2:0] t_op, input logic [31:0] t_d1,
                         input logic [31:0] t_d2, input logic t_req, output int lat);
        @(negedge clk);
        start = 1'b1; op = t_op; d1 = t_d1; d2 = t_d2; req = t_req;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = 3'd0; req = 1'b0;
        lat = 0;
        while (busy && lat < 100) begin
            lat++;
            @(negedge clk);
        end
    endtask

    int lat;
    int e_lat;

    initial begin
        reset = 1'b1; req = 1'b0; start = 1'b0; op = 3'd0; d1 = 32'd0; d2 = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        vecs[0]  = '{3'd1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, MC};
        vecs[1]  = '{3'd4, 32'd7,         32'd2,        32'd1,         32'd3,         DC};
        vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
        vecs[3]  = '{3'd5, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFD, 0};
        vecs[4]  = '{3'd6, 32'h0000_5678, 32'd0,        32'h0000_1234, 32'h0000_5678, 0};
        vecs[5]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, DC};
        vecs[6]  = '{3'd4, 32'd9,         32'd0,        32'd9,         32'hFFFF_FFFF, DC};
        vecs[7]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,        MC};
        vecs[8]  = '{3'd0, 32'hDEAD_BEEF, 32'd3,        32'hFFFF_FFFE, 32'd1,         0};
        vecs[9]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        MC};
        vecs[10] = '{3'd3, 32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, DC};
        vecs[11] = '{3'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,        DC};
        vecs[12] = '{3'd1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, MC};

        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].op, vecs[i].d1, vecs[i].d2, 1'b0, lat);
            e_lat = model_op(vecs[i].op, vecs[i].d1, vecs[i].d2);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].e_lat));
            check($sformatf("vec%0d_hi", i), hi, vecs[i].e_hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].e_lo);
        end

        // Back-to-back mthi/mtlo: each visible one edge later, no busy.
        @(negedge clk);
        start = 1'b1; op = 3'd5; d1 = 32'h0000_1234;
        @(posedge clk);
        @(negedge clk);
        check("b2b_hi", hi, 32'h0000_1234);
        check("b2b_busy0", {31'd0, busy}, 32'd0);
        op = 3'd6; d1 = 32'h0000_5678;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        check("b2b_lo", lo, 32'h0000_5678);
        check("b2b_hi_kept", hi, 32'h0000_1234);
        check("b2b_busy1", {31'd0, busy}, 32'd0);
        m_hi = 32'h0000_1234; m_lo = 32'h0000_5678;

        // Start suppressed by req.
        do_op(3'd5, 32'hAAAA_AAAA, 32'd0, 1'b0, lat);
        do_op(3'd6, 32'hAAAA_AAAA, 32'd0, 1'b0, lat);
        do_op(3'd1, 32'd3, 32'd4, 1'b1, lat);
        check("req_start_lat", 32'(lat), 32'd0);
        check("req_start_hi", hi, 32'hAAAA_AAAA);
        check("req_start_lo", lo, 32'hAAAA_AAAA);

        // req two cycles into an accepted multu does not cancel it.
        @(negedge clk);
        start = 1'b1; op = 3'd2; d1 = 32'h0001_0000; d2 = 32'h0001_0000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        lat = 0;
        while (busy && lat < 100) begin
            lat++;
            req = (lat == 2);
            @(negedge clk);
        end
        req = 1'b0;
        check("req_mid_lat", 32'(lat), 32'(MC));
        check("req_mid_hi", hi, 32'd1);
        check("req_mid_lo", lo, 32'd0);

        // Reset in the third busy cycle of a div.
        @(negedge clk);
        start = 1'b1; op = 3'd3; d1 = 32'd100; d2 = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        repeat (2) @(negedge clk);
        check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        repeat (DC + 2) @(negedge clk);
        check("rst_mid_no_late_commit", lo, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;

        // madd from hi=0, lo=0xFFFFFFFF with 1*1.
        do_op(3'd5, 32'd0, 32'd0, 1'b0, lat);
        do_op(3'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, lat);
        do_op(3'd7, 32'd1, 32'd1, 1'b0, lat);
`ifdef MDU_MADD_EN
        check("madd_lat", 32'(lat), 32'(MC));
        check("madd_hi", hi, 32'd1);
        check("madd_lo", lo, 32'd0);
        m_hi = 32'd1; m_lo = 32'd0;
`else
        check("madd_off_lat", 32'(lat), 32'd0);
        check("madd_off_hi", hi, 32'd0);
        check("madd_off_lo", lo, 32'hFFFF_FFFF);
        m_hi = 32'd0; m_lo = 32'hFFFF_FFFF;
`endif

        // Randomized ops against the model.
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  r_op;
            logic [31:0] r_d1;
            logic [31:0] r_d2;
            logic        r_req;
            int          mode;
            r_op  = 3'($urandom_range(0, 7));
            mode  = $urandom_range(0, 3);
            r_d1  = $urandom;
            r_d2  = $urandom;
            if (mode == 1) begin
                r_d1 = 32'($urandom_range(0, 15));
                r_d2 = 32'($urandom_range(0, 3));
            end else if (mode == 2) begin
                r_d1 = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
                r_d2 = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd0;
            end
            r_req = ($urandom_range(0, 7) == 0);
            do_op(r_op, r_d1, r_d2, r_req, lat);
            e_lat = r_req ? 0 : model_op(r_op, r_d1, r_d2);
            check($sformatf("rnd%0d_op%0d_lat", i, r_op), 32'(lat), 32'(e_lat));
            check($sformatf("rnd%0d_op%0d_hi", i, r_op), hi, m_hi);
            check($sformatf("rnd%0d_op%0d_lo", i, r_op), lo, m_lo);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
